instr_fetch_seq: RTL and testbench

- Upstream sequencer for the cpu block. Owns the program counter and fetches 16-bit instructions from instruction memory over a request/valid handshake.
- Loads each instruction into the cpu instruction register, launches it with s, and waits for w to signal completion.
- Stops on a HALT opcode, an unsupported opcode, or a cpu acknowledge timeout.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/pc_counter.sv | 22 ++
 rtl/instr_fetch_seq.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    LOAD,
    START,
    EXEC,
    HALTED
  } state_t;

  localparam int         INSTR_W = 16;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Opcodes the cpu can actually decode; anything else would hang it in Decode.
  function automatic logic is_exec_op(input logic [2:0] op);
    return (op == OP_ALU) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset to START_PC, increments on inc
// and wraps modulo 2^PC_W.
module pc_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Advance the pc by one each cycle inc is high; natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= START_PC;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: fetches 16-bit words from instruction memory,
// loads them into the cpu instruction register and launches them, stopping on
// HALT, an undecodable opcode, or a cpu acknowledge timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for run=1 with the cpu idle (cpu_w=1)
// FETCH    | mem_rd pulse, mem_addr = pc
// WAIT_MEM | waiting for mem_valid; decode opcode of returned word
// LOAD     | cpu_load pulse with cpu_in = fetched word
// START    | cpu_s held high until cpu_w falls or the ack timer expires
// EXEC     | cpu executing; on cpu_w=1 advance pc, then fetch or idle
// HALTED   | sticky stop; left only through reset
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] START_PC    = '0,
  parameter logic [2:0]      HALT_OP     = OP_HALT,
  parameter int              ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               mem_rd,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] cpu_in,
  output logic               cpu_load,
  output logic               cpu_s,
  input  logic               cpu_w,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  localparam int              CNT_W   = $clog2(ACK_TIMEOUT + 1);
  // cpu_s is high for ACK_TIMEOUT cycles at most; the last one is count ACK_TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [2:0]       op;
  logic             pc_inc;

  assign op       = mem_rdata[15:13];
  assign mem_addr = pc;
  // pc only moves once the cpu reports completion of an issued instruction.
  assign pc_inc   = (state == EXEC) && cpu_w;

  pc_counter #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // Sequencer FSM; every output is set on the transition into the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      cpu_in   <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      to_cnt   <= '0;
    end else begin
      mem_rd   <= 1'b0;
      cpu_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run && cpu_w) begin
            state  <= FETCH;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        FETCH: begin
          state <= WAIT_MEM;
        end
        WAIT_MEM: begin
          if (mem_valid) begin
            if (op == HALT_OP) begin
              state  <= HALTED;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else if (!is_exec_op(op)) begin
              state  <= HALTED;
              halted <= 1'b1;
              err    <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state    <= LOAD;
              cpu_in   <= mem_rdata;
              cpu_load <= 1'b1;
            end
          end
        end
        LOAD: begin
          state  <= START;
          cpu_s  <= 1'b1;
          to_cnt <= '0;
        end
        START: begin
          if (!cpu_w) begin
            state <= EXEC;
            cpu_s <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state  <= HALTED;
            cpu_s  <= 1'b0;
            halted <= 1'b1;
            err    <= 1'b1;
            busy   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EXEC: begin
          if (cpu_w) begin
            if (run) begin
              state  <= FETCH;
              mem_rd <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: memory and cpu behavioural models, directed
// scenarios and randomized programs checked against a program-level predictor.
module tb_instr_fetch_seq;

  localparam int ACK = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (START_PC = 0)
  logic        reset, run, mem_rd, mem_valid, cpu_load, cpu_s, busy, halted, err;
  logic        cpu_w = 1'b1;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_rdata, cpu_in;

  // wrap DUT (START_PC = FF)
  logic        w_run, w_mem_rd, w_mem_valid, w_cpu_load, w_cpu_s, w_busy, w_halted, w_err;
  logic        w_cpu_w = 1'b1;
  logic [7:0]  w_mem_addr, w_pc;
  logic [15:0] w_mem_rdata, w_cpu_in;

  instr_fetch_seq u_dut (
    .clk(clk), .reset(reset), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .cpu_in(cpu_in), .cpu_load(cpu_load),
    .cpu_s(cpu_s), .cpu_w(cpu_w), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  instr_fetch_seq #(.START_PC(8'hFF)) u_wrap (
    .clk(clk), .reset(reset), .run(w_run), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr),
    .mem_rdata(w_mem_rdata), .mem_valid(w_mem_valid), .cpu_in(w_cpu_in), .cpu_load(w_cpu_load),
    .cpu_s(w_cpu_s), .cpu_w(w_cpu_w), .pc(w_pc), .busy(w_busy), .halted(w_halted), .err(w_err)
  );

  int checks = 0;
  int errors = 0;

  // program, per-instruction cpu behaviour and per-fetch memory latency
  logic [15:0] mem [256];
  logic [15:0] w_mem [256];
  int dly [64];
  int bsy [64];
  int lat [64];
  bit spurious = 1'b0;

  // model / monitor state
  int m_pend = 0, m_rem = 0, m_addr = 0, n_fetch = 0;
  int c_state = 0, c_cnt = 0, c_idx = 0, s_run = 0, viol = 0;
  logic [15:0] got_loads[$];
  int          got_slen[$];
  int          got_fetch[$];

  int w_pend = 0, w_cst = 0, w_cnt = 0;
  logic [7:0]  w_addr = 8'h00;
  logic [15:0] w_loads[$];
  int          w_fetch[$];

  // expected results from the predictor
  logic [15:0] exp_loads[$];
  int          exp_slen[$];
  int          exp_fetch[$];
  int          exp_pc;
  logic        exp_err;

  // Memory responder, cpu model and monitor, all on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      m_pend = 0; mem_valid = 1'b0; mem_rdata = 16'h0000; n_fetch = 0;
      cpu_w = 1'b1; c_state = 0; c_cnt = 0; c_idx = 0; s_run = 0; viol = 0;
      got_loads.delete(); got_slen.delete(); got_fetch.delete();
    end else begin
      if (m_pend != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          mem_valid = 1'b1; mem_rdata = mem[m_addr]; m_pend = 0;
        end else begin
          mem_valid = 1'b0;
        end
      end else begin
        mem_valid = spurious && ($urandom_range(0, 3) == 0);
        mem_rdata = 16'($urandom);
      end
      if (mem_rd) begin
        if (m_pend != 0) viol++;
        m_pend = 1; m_addr = int'(mem_addr); m_rem = lat[n_fetch % 64];
        got_fetch.push_back(int'(mem_addr)); n_fetch++; mem_valid = 1'b0;
      end
      if (cpu_s && cpu_load) viol++;
      if (cpu_load) got_loads.push_back(cpu_in);
      if (cpu_s) s_run++;
      else if (s_run > 0) begin got_slen.push_back(s_run); s_run = 0; end
      case (c_state)
        0: if (cpu_s) begin
             c_cnt++;
             if (c_cnt >= dly[c_idx]) begin cpu_w = 1'b0; c_state = 1; c_cnt = 0; end
           end
        default: begin
          c_cnt++;
          if (c_cnt >= bsy[c_idx]) begin cpu_w = 1'b1; c_state = 0; c_cnt = 0; c_idx++; end
        end
      endcase
    end
  end

  // Fixed-behaviour models for the wrap DUT: 1-cycle memory, cpu drops w 2 cycles after s.
  always @(negedge clk) begin
    if (reset) begin
      w_pend = 0; w_mem_valid = 1'b0; w_mem_rdata = 16'h0000; w_cpu_w = 1'b1;
      w_cst = 0; w_cnt = 0; w_fetch.delete(); w_loads.delete();
    end else begin
      w_mem_valid = 1'b0;
      if (w_pend != 0) begin w_mem_valid = 1'b1; w_mem_rdata = w_mem[w_addr]; w_pend = 0; end
      if (w_mem_rd) begin w_pend = 1; w_addr = w_mem_addr; w_fetch.push_back(int'(w_mem_addr)); end
      if (w_cpu_load) w_loads.push_back(w_cpu_in);
      if (w_cst == 0) begin
        if (w_cpu_s) begin
          w_cnt++;
          if (w_cnt >= 2) begin w_cpu_w = 1'b0; w_cst = 1; w_cnt = 0; end
        end
      end else begin
        w_cpu_w = 1'b1; w_cst = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; w_run = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Walks the program the way the cpu would see it: which words get issued,
  // how long each start is held, where fetching stops and why.
  task automatic predict();
    int p = 0;
    int i = 0;
    logic [15:0] wd;
    logic [2:0]  op;
    exp_loads.delete(); exp_slen.delete(); exp_fetch.delete(); exp_err = 1'b0;
    for (int g = 0; g < 300; g++) begin
      exp_fetch.push_back(p);
      wd = mem[p];
      op = wd[15:13];
      if (op == 3'b111) begin exp_err = 1'b0; break; end
      if (op != 3'b101 && op != 3'b110) begin exp_err = 1'b1; break; end
      exp_loads.push_back(wd);
      if (dly[i] > ACK) begin exp_slen.push_back(ACK); exp_err = 1'b1; break; end
      exp_slen.push_back(dly[i]);
      i++;
      p = (p + 1) % 256;
    end
    exp_pc = p;
  endtask

  task automatic check_scenario(input string tag, input int budget);
    int n = 0;
    predict();
    while (!halted && n < budget) begin tick(); n++; end
    repeat (3) tick();
    check({tag, " halted"}, 32'(halted), 32'd1);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " pc"}, 32'(pc), 32'(exp_pc));
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " strobes"}, 32'({mem_rd, cpu_load, cpu_s}), 32'd0);
    check({tag, " n_loads"}, 32'(got_loads.size()), 32'(exp_loads.size()));
    for (int i = 0; i < got_loads.size() && i < exp_loads.size(); i++)
      check($sformatf("%s load[%0d]", tag, i), 32'(got_loads[i]), 32'(exp_loads[i]));
    check({tag, " n_starts"}, 32'(got_slen.size()), 32'(exp_slen.size()));
    for (int i = 0; i < got_slen.size() && i < exp_slen.size(); i++)
      check($sformatf("%s s_len[%0d]", tag, i), 32'(got_slen[i]), 32'(exp_slen[i]));
    check({tag, " n_fetch"}, 32'(got_fetch.size()), 32'(exp_fetch.size()));
    for (int i = 0; i < got_fetch.size() && i < exp_fetch.size(); i++)
      check($sformatf("%s fetch[%0d]", tag, i), 32'(got_fetch[i]), 32'(exp_fetch[i]));
    check({tag, " invariants"}, 32'(viol), 32'd0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 64; i++) begin dly[i] = 2; bsy[i] = 1; lat[i] = 1; end
  endtask

  initial begin
    int n;
    int len;
    int k;
    reset = 1'b1; run = 1'b0; w_run = 1'b0;
    for (int i = 0; i < 256; i++) w_mem[i] = 16'h0000;
    w_mem[8'hFF] = 16'hA123;
    w_mem[8'h00] = 16'hE000;
    clear_prog();
    do_reset();

    // reset values
    check("rst pc", 32'(pc), 32'h00);
    check("rst mem_addr", 32'(mem_addr), 32'h00);
    check("rst cpu_in", 32'(cpu_in), 32'h0000);
    check("rst strobes", 32'({mem_rd, cpu_load, cpu_s}), 32'd0);
    check("rst flags", 32'({busy, halted, err}), 32'd0);
    check("rst wrap pc", 32'(w_pc), 32'hFF);

    // MOV then HALT
    clear_prog();
    mem[0] = 16'hD105; mem[1] = 16'hE000;
    run = 1'b1;
    check_scenario("movhalt", 300);
    repeat (5) tick();
    check("movhalt pc sticky", 32'(pc), 32'd1);
    check("movhalt halted sticky", 32'(halted), 32'd1);

    // illegal opcode at address 0
    do_reset();
    clear_prog();
    run = 1'b1;
    check_scenario("illegal", 300);

    // cpu never acknowledges
    do_reset();
    clear_prog();
    mem[0] = 16'hA001; dly[0] = 1000;
    run = 1'b1;
    check_scenario("timeout", 300);

    // pc wrap from FF to 00
    w_run = 1'b1;
    n = 0;
    while (!w_halted && n < 300) begin tick(); n++; end
    repeat (3) tick();
    check("wrap halted", 32'(w_halted), 32'd1);
    check("wrap err", 32'(w_err), 32'd0);
    check("wrap pc", 32'(w_pc), 32'h00);
    check("wrap n_loads", 32'(w_loads.size()), 32'd1);
    if (w_loads.size() > 0) check("wrap load", 32'(w_loads[0]), 32'hA123);
    check("wrap n_fetch", 32'(w_fetch.size()), 32'd2);
    if (w_fetch.size() > 1) begin
      check("wrap fetch0", 32'(w_fetch[0]), 32'hFF);
      check("wrap fetch1", 32'(w_fetch[1]), 32'h00);
    end
    w_run = 1'b0;

    // run dropped while the first instruction executes
    do_reset();
    clear_prog();
    mem[0] = 16'hA001; mem[1] = 16'hE000; bsy[0] = 8;
    run = 1'b1;
    n = 0;
    while (!cpu_s && n < 50) begin tick(); n++; end
    check("rundrop s seen", 32'(cpu_s), 32'd1);
    n = 0;
    while (cpu_s && n < 50) begin tick(); n++; end
    check("rundrop s fell", 32'(cpu_s), 32'd0);
    run = 1'b0;
    repeat (15) tick();
    check("rundrop pc", 32'(pc), 32'd1);
    check("rundrop idle", 32'({busy, halted, err}), 32'd0);
    check("rundrop n_fetch", 32'(got_fetch.size()), 32'd1);
    run = 1'b1;
    check_scenario("rundrop resume", 300);

    // reset while cpu_s is held in START
    do_reset();
    clear_prog();
    mem[0] = 16'hA001; dly[0] = 1000;
    run = 1'b1;
    n = 0;
    while (!cpu_s && n < 50) begin tick(); n++; end
    repeat (3) tick();
    check("midrst s before", 32'(cpu_s), 32'd1);
    reset = 1'b1; run = 1'b0;
    tick();
    check("midrst cpu_s", 32'(cpu_s), 32'd0);
    check("midrst pc", 32'(pc), 32'h00);
    check("midrst flags", 32'({busy, halted, err}), 32'd0);
    reset = 1'b0;
    tick();
    check("midrst stays idle", 32'({busy, mem_rd}), 32'd0);

    // randomized programs
    for (int s = 0; s < 20; s++) begin
      do_reset();
      clear_prog();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        mem[i] = {($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110, 13'($urandom)};
      k = $urandom_range(0, 5);
      mem[len] = {(k == 5) ? 3'b111 : 3'(k), 13'($urandom)};
      for (int i = 0; i < 64; i++) begin
        dly[i] = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 6);
        bsy[i] = $urandom_range(1, 4);
        lat[i] = $urandom_range(1, 4);
      end
      spurious = 1'b1;
      run = 1'b1;
      check_scenario($sformatf("rand%0d", s), 3000);
      spurious = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
